vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/sync_edge_det.sv | 29 ++
 rtl/vga_sync_decoder.sv | 237 +++++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and sync-tracker state encoding for the VGA
// timing generator and decoder.
package vga_timing_pkg;

    localparam int unsigned HPIXELS_DEF     = 800;
    localparam int unsigned VLINES_DEF      = 521;
    localparam int unsigned HPULSE_DEF      = 96;
    localparam int unsigned HBP_DEF         = 144;
    localparam int unsigned HFP_DEF         = 784;
    localparam int unsigned VPULSE_DEF      = 2;
    localparam int unsigned VBP_DEF         = 31;
    localparam int unsigned VFP_DEF         = 511;
    localparam int unsigned LOCK_FRAMES_DEF = 2;

    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StSync   = 2'd1,
        StLocked = 2'd2
    } sync_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (val == CNT_MAX) ? val : val + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers one active-low sync input and flags its edges against the previous sample.
// Both history registers reset to the idle (high) level.
module sync_edge_det (
    input  logic dclk,
    input  logic clr_n,
    input  logic i_sync,
    output logic o_sample,
    output logic o_rise,
    output logic o_fall
);

    logic r_sample;
    logic r_prev;

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_sample <= 1'b1;
            r_prev   <= 1'b1;
        end else begin
            r_sample <= i_sync;
            r_prev   <= r_sample;
        end
    end

    assign o_sample = r_sample;
    assign o_rise   = r_sample & ~r_prev;
    assign o_fall   = ~r_sample & r_prev;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from an incoming VGA sync/colour stream, checks its timing
// and qualifies active pixels once the stream has been locked for LOCK_FRAMES frames.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int unsigned HPIXELS     = HPIXELS_DEF,
    parameter int unsigned VLINES      = VLINES_DEF,
    parameter int unsigned HPULSE      = HPULSE_DEF,
    parameter int unsigned HBP         = HBP_DEF,
    parameter int unsigned HFP         = HFP_DEF,
    parameter int unsigned VPULSE      = VPULSE_DEF,
    parameter int unsigned VBP         = VBP_DEF,
    parameter int unsigned VFP         = VFP_DEF,
    parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF
) (
    input  logic       dclk,
    input  logic       clr_n,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [2:0] red,
    input  logic [2:0] green,
    input  logic [2:0] blue,
    output logic       locked,
    output logic       pix_valid,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic [8:0] pix_rgb,
    output logic       frame_start,
    output logic       timing_err,
    output logic [7:0] err_count
);

    localparam logic [CNT_W-1:0] HLAST    = CNT_W'(HPIXELS - 1);
    localparam logic [CNT_W-1:0] VLAST    = CNT_W'(VLINES - 1);
    localparam logic [CNT_W-1:0] HPULSE_C = CNT_W'(HPULSE);
    localparam logic [CNT_W-1:0] VPULSE_C = CNT_W'(VPULSE);
    localparam logic [CNT_W-1:0] HBP_C    = CNT_W'(HBP);
    localparam logic [CNT_W-1:0] HFP_C    = CNT_W'(HFP);
    localparam logic [CNT_W-1:0] VBP_C    = CNT_W'(VBP);
    localparam logic [CNT_W-1:0] VFP_C    = CNT_W'(VFP);

    localparam int unsigned CLEAN_W = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
    localparam logic [CLEAN_W-1:0] LOCK_LAST = CLEAN_W'(LOCK_FRAMES - 1);

    // Stage s1: registered inputs
    logic       w_hs_s1;
    logic       w_hs_rise;
    logic       w_hs_fall;
    logic       w_vs_s1;
    logic       w_vs_rise;
    logic       w_vs_fall;
    logic [8:0] r_rgb_s1;

    sync_edge_det u_hs_det (
        .dclk     (dclk),
        .clr_n    (clr_n),
        .i_sync   (hsync),
        .o_sample (w_hs_s1),
        .o_rise   (w_hs_rise),
        .o_fall   (w_hs_fall)
    );

    sync_edge_det u_vs_det (
        .dclk     (dclk),
        .clr_n    (clr_n),
        .i_sync   (vsync),
        .o_sample (w_vs_s1),
        .o_rise   (w_vs_rise),
        .o_fall   (w_vs_fall)
    );

    logic w_unused_edges;
    assign w_unused_edges = w_hs_s1 ^ w_vs_fall;

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_rgb_s1 <= '0;
        end else begin
            r_rgb_s1 <= {red, green, blue};
        end
    end

    // Position counters; the _d values are the coordinates of the current s1 sample
    logic [CNT_W-1:0] r_hcount;
    logic [CNT_W-1:0] r_vcount;
    logic [CNT_W-1:0] w_hcount_d;
    logic [CNT_W-1:0] w_vcount_d;
    logic             r_vs_at_hfall;
    logic             w_restart;

    assign w_restart = w_hs_fall & ~w_vs_s1 & r_vs_at_hfall;

    always_comb begin
        w_hcount_d = w_hs_fall ? '0 : sat_inc(r_hcount);
        w_vcount_d = r_vcount;
        if (w_hs_fall) begin
            w_vcount_d = w_restart ? '0 : sat_inc(r_vcount);
        end
    end

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_vs_at_hfall <= 1'b1;
        end else begin
            r_hcount <= w_hcount_d;
            r_vcount <= w_vcount_d;
            if (w_hs_fall) begin
                r_vs_at_hfall <= w_vs_s1;
            end
        end
    end

    // Timing checks
    logic w_err_hlen;
    logic w_err_hpulse;
    logic w_err_vlen;
    logic w_err_vpulse;
    logic w_err_wdog;
    logic w_err;

    assign w_err_hlen   = w_hs_fall & (r_hcount != HLAST);
    assign w_err_hpulse = w_hs_rise & (w_hcount_d != HPULSE_C);
    assign w_err_vlen   = w_restart & (r_vcount != VLAST);
    assign w_err_vpulse = w_vs_rise & (w_vcount_d != VPULSE_C);
    // Fires once on arrival at saturation, not on every saturated sample
    assign w_err_wdog   = (w_hcount_d == CNT_MAX) & (r_hcount != CNT_MAX);
    assign w_err        = w_err_hlen | w_err_hpulse | w_err_vlen | w_err_vpulse | w_err_wdog;

    // Lock FSM
    sync_state_e        r_state;
    sync_state_e        w_state_d;
    logic [CLEAN_W-1:0] r_clean;
    logic [CLEAN_W-1:0] w_clean_d;
    logic               w_err_evt;

    assign w_err_evt = w_err & (r_state != StSearch);

    always_comb begin
        w_state_d = r_state;
        w_clean_d = r_clean;
        unique case (r_state)
            StSearch: begin
                if (w_restart) begin
                    w_state_d = StSync;
                    w_clean_d = '0;
                end
            end
            StSync: begin
                if (w_err) begin
                    w_state_d = StSearch;
                end else if (w_restart) begin
                    if (r_clean >= LOCK_LAST) begin
                        w_state_d = StLocked;
                        w_clean_d = '0;
                    end else begin
                        w_clean_d = r_clean + CLEAN_W'(1);
                    end
                end
            end
            StLocked: begin
                if (w_err) begin
                    w_state_d = StSearch;
                end
            end
            default: begin
                w_state_d = StSearch;
                w_clean_d = '0;
            end
        endcase
    end

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= StSearch;
            r_clean <= '0;
        end else begin
            r_state <= w_state_d;
            r_clean <= w_clean_d;
        end
    end

    // Output stage
    logic             w_active;
    logic [CNT_W-1:0] w_x;
    logic             w_frame_start;

    assign w_active = (w_state_d == StLocked)
                    & (w_hcount_d >= HBP_C) & (w_hcount_d < HFP_C)
                    & (w_vcount_d >= VBP_C) & (w_vcount_d < VFP_C);
    assign w_x           = w_hcount_d - HBP_C;
    assign w_frame_start = w_active & (w_hcount_d == HBP_C) & (w_vcount_d == VBP_C);

    logic       r_locked;
    logic       r_pix_valid;
    logic [9:0] r_x;
    logic [8:0] r_y;
    logic [8:0] r_pix_rgb;
    logic       r_frame_start;
    logic       r_timing_err;
    logic [7:0] r_err_count;

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_locked      <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_pix_rgb     <= '0;
            r_frame_start <= 1'b0;
            r_timing_err  <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_locked      <= (w_state_d == StLocked);
            r_pix_valid   <= w_active;
            r_x           <= w_active ? w_x : '0;
            r_y           <= w_active ? 9'(w_vcount_d - VBP_C) : '0;
            r_pix_rgb     <= w_active ? r_rgb_s1 : '0;
            r_frame_start <= w_frame_start;
            r_timing_err  <= w_err_evt;
            if (w_err_evt && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign locked      = r_locked;
    assign pix_valid   = r_pix_valid;
    assign x           = r_x;
    assign y           = r_y;
    assign pix_rgb     = r_pix_rgb;
    assign frame_start = r_frame_start;
    assign timing_err  = r_timing_err;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a scaled-down 40x20 raster (28x14 active),
// plus directed checks for lock timing, line-length, watchdog, saturation and reset.
module tb_vga_sync_decoder;

    localparam int HP     = 40;
    localparam int HPW    = 4;
    localparam int HB     = 8;
    localparam int HF     = 36;
    localparam int VL     = 20;
    localparam int VPW    = 2;
    localparam int VB     = 4;
    localparam int VF     = 18;
    localparam int LF     = 2;
    localparam int FRAME  = HP * VL;
    localparam int ACTIVE = (HF - HB) * (VF - VB);

    logic       dclk = 1'b0;
    logic       clr_n = 1'b1;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic [2:0] red = '0;
    logic [2:0] green = '0;
    logic [2:0] blue = '0;
    logic       locked;
    logic       pix_valid;
    logic [9:0] x;
    logic [8:0] y;
    logic [8:0] pix_rgb;
    logic       frame_start;
    logic       timing_err;
    logic [7:0] err_count;

    vga_sync_decoder #(
        .HPIXELS     (HP),
        .VLINES      (VL),
        .HPULSE      (HPW),
        .HBP         (HB),
        .HFP         (HF),
        .VPULSE      (VPW),
        .VBP         (VB),
        .VFP         (VF),
        .LOCK_FRAMES (LF)
    ) u_dut (
        .dclk        (dclk),
        .clr_n       (clr_n),
        .hsync       (hsync),
        .vsync       (vsync),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .locked      (locked),
        .pix_valid   (pix_valid),
        .x           (x),
        .y           (y),
        .pix_rgb     (pix_rgb),
        .frame_start (frame_start),
        .timing_err  (timing_err),
        .err_count   (err_count)
    );

    always #20 dclk = ~dclk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model of the decoder, advanced once per sample entering stage s1
    int m_h, m_v, m_state, m_clean, m_errs;
    bit m_hs_last, m_vs_last, m_vs_hfall;

    function automatic void model_reset();
        m_h = 0; m_v = 0; m_state = 0; m_clean = 0; m_errs = 0;
        m_hs_last = 1'b1; m_vs_last = 1'b1; m_vs_hfall = 1'b1;
    endfunction

    function automatic logic [39:0] model_step(input bit hs, input bit vs, input logic [8:0] rgb);
        bit hfall, hrise, vrise, restart, err, te, pv, fs;
        int h, v, ns;
        hfall   = !hs && m_hs_last;
        hrise   = hs && !m_hs_last;
        vrise   = vs && !m_vs_last;
        restart = hfall && !vs && m_vs_hfall;
        h = hfall ? 0 : ((m_h < 1023) ? m_h + 1 : 1023);
        v = m_v;
        if (hfall) v = restart ? 0 : ((m_v < 1023) ? m_v + 1 : 1023);
        err = (hfall && m_h != HP - 1) || (hrise && h != HPW) || (restart && m_v != VL - 1)
           || (vrise && v != VPW) || (h == 1023 && m_h != 1023);
        ns = m_state;
        case (m_state)
            0: if (restart) begin ns = 1; m_clean = 0; end
            1: if (err) ns = 0;
               else if (restart) begin
                   m_clean++;
                   if (m_clean >= LF) ns = 2;
               end
            default: if (err) ns = 0;
        endcase
        te = err && (m_state != 0);
        if (te && m_errs < 255) m_errs++;
        pv = (ns == 2) && h >= HB && h < HF && v >= VB && v < VF;
        fs = pv && h == HB && v == VB;
        m_h = h; m_v = v; m_hs_last = hs; m_vs_last = vs; m_state = ns;
        if (hfall) m_vs_hfall = vs;
        return {ns == 2, pv, pv ? 10'(h - HB) : 10'd0, pv ? 9'(v - VB) : 9'd0,
                pv ? rgb : 9'd0, fs, te, 8'(m_errs)};
    endfunction

    logic [39:0] sb_q[$];
    int mon_pv, mon_fs, mon_te, cyc, lock_rise;
    bit prev_locked;

    task automatic tick(input logic hs, input logic vs, input logic [8:0] rgb);
        logic [39:0] got;
        hsync = hs;
        vsync = vs;
        {red, green, blue} = rgb;
        sb_q.push_back(model_step(hs, vs, rgb));
        @(posedge dclk);
        #1;
        got = {locked, pix_valid, x, y, pix_rgb, frame_start, timing_err, err_count};
        if (sb_q.size() > 1) check_eq("outs", got, sb_q.pop_front());
        if (pix_valid) mon_pv++;
        if (timing_err) mon_te++;
        if (frame_start) begin
            mon_fs++;
            check_eq("fs_pixel", {pix_valid, x, y, pix_rgb}, {1'b1, 10'd0, 9'd0, 9'h1C7});
        end
        if (locked && !prev_locked && lock_rise < 0) lock_rise = cyc;
        prev_locked = locked;
        cyc++;
    endtask

    task automatic clear_mon();
        mon_pv = 0; mon_fs = 0; mon_te = 0;
    endtask

    task automatic px(input int l, input int c);
        logic [8:0] rgb;
        rgb = (l == VB && c == HB) ? 9'h1C7 : 9'($urandom);
        tick((c < HPW) ? 1'b0 : 1'b1, (l < VPW) ? 1'b0 : 1'b1, rgb);
    endtask

    task automatic send_frame(input int short_line);
        for (int l = 0; l < VL; l++) begin
            for (int c = 0; c < ((l == short_line) ? HP - 1 : HP); c++) px(l, c);
        end
    endtask

    task automatic send_part(input int p0, input int p1);
        for (int p = p0; p < p1; p++) px(p / HP, p % HP);
    endtask

    task automatic do_reset();
        #2;
        clr_n = 1'b0;
        #1;
        check_eq("rst_outs", {locked, pix_valid, x, y, pix_rgb, frame_start, timing_err, err_count},
                 40'd0);
        repeat (2) @(posedge dclk);
        @(negedge dclk);
        clr_n = 1'b1;
        model_reset();
        sb_q.delete();
        // First edge after release processes the idle reset contents of s1
        sb_q.push_back(model_step(1'b1, 1'b1, 9'd0));
        cyc = 0;
        lock_rise = -1;
        prev_locked = 1'b0;
    endtask

    initial begin
        do_reset();

        // Clean stream: lock at the start of frame 3
        for (int f = 1; f <= 4; f++) begin
            clear_mon();
            send_frame(-1);
            check_eq("frame_pv", mon_pv, (f >= 3) ? ACTIVE : 0);
            check_eq("frame_fs", mon_fs, (f >= 3) ? 1 : 0);
            check_eq("frame_te", mon_te, 0);
        end
        check_eq("lock_rise_cyc", lock_rise, 2 * FRAME + 1);

        // One short line while locked
        clear_mon();
        send_frame(10);
        check_eq("short_te", mon_te, 1);
        check_eq("short_errc", err_count, 1);
        check_eq("short_unlock", locked, 0);
        clear_mon();
        send_frame(-1);
        send_frame(-1);
        check_eq("relock_pending", locked, 0);
        check_eq("relock_te", mon_te, 0);
        clear_mon();
        send_frame(-1);
        check_eq("relock", locked, 1);
        check_eq("relock_pv", mon_pv, ACTIVE);

        // hsync stuck high: watchdog
        clear_mon();
        for (int i = 0; i < HPW; i++) tick(1'b0, 1'b0, 9'($urandom));
        for (int i = 0; i < 1100; i++) tick(1'b1, 1'b0, 9'($urandom));
        check_eq("wdog_te", mon_te, 1);
        check_eq("wdog_errc", err_count, 2);
        check_eq("wdog_unlock", locked, 0);
        check_eq("wdog_pv", mon_pv, 0);

        // 300 errors: restart into SYNC then a bad pulse, repeatedly
        clear_mon();
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'b1, 9'd0);
            tick(1'b1, 1'b1, 9'd0);
            tick(1'b0, 1'b0, 9'd0);
            tick(1'b1, 1'b1, 9'd0);
        end
        tick(1'b1, 1'b1, 9'd0);
        tick(1'b1, 1'b1, 9'd0);
        check_eq("sat_te", mon_te, 300);
        check_eq("sat_errc", err_count, 255);

        // Relock, then reset mid-line on an active pixel
        for (int f = 0; f < 4; f++) send_frame(-1);
        check_eq("relock2", locked, 1);
        send_part(0, 6 * HP + 20);
        check_eq("pre_rst_pv", pix_valid, 1);
        do_reset();
        clear_mon();
        send_part(6 * HP + 20, FRAME);
        for (int f = 0; f < 3; f++) send_frame(-1);
        check_eq("post_rst_te", mon_te, 0);
        check_eq("post_rst_lock", locked, 1);
        check_eq("post_rst_errc", err_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
